// File: rtl/chain_alu.sv
// chain_alu: handshaked chained arithmetic unit.
// Collects up to DEPTH signed operands, each with a trailing operator
// (00 add, 01 sub, 10 mul, 11 div), then folds the chain into one
// WIDTH-bit signed result with status flags.
// Optional build macro: CHAIN_ALU_PRECEDENCE_EN (mul/div bind tighter
// than add/sub; default build is strict left-to-right).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand token handshake
//   in_operand, in_op     operand and operator applied after it
//   in_last               token ends the expression
//   out_valid/out_ready   result handshake
//   out_result            signed result
//   out_neg, out_zero     sign / zero of out_result
//   out_div0, out_ovf     divide-by-zero, sticky overflow
//   busy                  high while evaluating or holding a result
module chain_alu #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_operand,
  input  logic [1:0]       in_op,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_neg,
  output logic             out_zero,
  output logic             out_div0,
  output logic             out_ovf,
  output logic             busy
);

`ifdef CHAIN_ALU_PRECEDENCE_EN
  localparam bit PREC = 1'b1;
`else
  localparam bit PREC = 1'b0;
`endif

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int BW    = $clog2(WIDTH + 1);
  localparam int SLOTS = 1 << CW;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  typedef enum logic [1:0] {COLLECT, EVAL, DIV, DONE} state_t;

  state_t state, state_d;

  logic [WIDTH-1:0] opnd [SLOTS];
  logic [1:0]       ops  [SLOTS];

  logic [CW-1:0]    cnt, cnt_d, idx, idx_d, idx_p1;
  logic [WIDTH-1:0] acc, acc_d, sum, sum_d;
  logic [WIDTH-1:0] dq, dq_d, dd, dd_d, rem, rem_d, res_d;
  logic [BW-1:0]    bcnt, bcnt_d;
  logic             sgn, sgn_d, qneg, qneg_d, ovf, ovf_d, div0_d;

  logic [WIDTH-1:0] res_q;
  logic             div0_q, ovf_q;

  logic [WIDTH-1:0]   b;
  logic [1:0]         cur_op;
  logic               at_end, last_step, prod_ovf;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     fin, as_r, trial;

  // Returns {overflow, wrapped result}.
  function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic sub);
    logic [WIDTH:0] s;
    s = sub ? ({x[WIDTH-1], x} - {y[WIDTH-1], y})
            : ({x[WIDTH-1], x} + {y[WIDTH-1], y});
    return {s[WIDTH] ^ s[WIDTH-1], s[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  assign idx_p1    = idx + CW'(1);
  assign b         = opnd[idx_p1];
  assign cur_op    = ops[idx];
  assign at_end    = (idx == cnt - CW'(1));
  assign last_step = (idx_p1 == cnt - CW'(1));
  assign prod      = $signed({{WIDTH{acc[WIDTH-1]}}, acc}) *
                     $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_ovf  = (|prod[2*WIDTH-1:WIDTH-1]) && !(&prod[2*WIDTH-1:WIDTH-1]);
  assign fin       = addsub(sum, acc, sgn);
  assign as_r      = addsub(acc, b, cur_op[0]);
  assign trial     = {rem, dq[WIDTH-1]} - {1'b0, dd};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    acc_d   = acc;
    sum_d   = sum;
    dq_d    = dq;
    dd_d    = dd;
    rem_d   = rem;
    bcnt_d  = bcnt;
    sgn_d   = sgn;
    qneg_d  = qneg;
    ovf_d   = ovf;
    res_d   = '0;
    div0_d  = 1'b0;
    case (state)
      COLLECT: begin
        if (in_valid) begin
          cnt_d = cnt + CW'(1);
          if (cnt == '0) acc_d = in_operand;
          if (in_last || cnt == LAST_IDX) begin
            state_d = EVAL;
            idx_d   = '0;
            sum_d   = '0;
            sgn_d   = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      EVAL: begin
        if (at_end) begin
          // Only reached for a single operand, or for the pending-term
          // cycle in precedence mode.
          state_d = DONE;
          if (PREC) begin
            res_d = fin[WIDTH-1:0];
            ovf_d = ovf | fin[WIDTH];
          end else begin
            res_d = acc;
          end
        end else begin
          case (cur_op)
            2'b10: begin
              acc_d = prod[WIDTH-1:0];
              ovf_d = ovf | prod_ovf;
            end
            2'b11: begin
              dq_d    = mag(acc);
              dd_d    = mag(b);
              rem_d   = '0;
              bcnt_d  = '0;
              qneg_d  = acc[WIDTH-1] ^ b[WIDTH-1];
              state_d = DIV;
            end
            default: begin
              if (PREC) begin
                // acc holds the mul/div term; fold it into sum with the
                // sign of the add/sub that preceded it.
                sum_d = fin[WIDTH-1:0];
                ovf_d = ovf | fin[WIDTH];
                sgn_d = cur_op[0];
                acc_d = b;
              end else begin
                acc_d = as_r[WIDTH-1:0];
                ovf_d = ovf | as_r[WIDTH];
              end
            end
          endcase
          if (cur_op != 2'b11) begin
            idx_d = idx_p1;
            if (!PREC && last_step) begin
              state_d = DONE;
              res_d   = acc_d;
            end
          end
        end
      end
      DIV: begin
        if (dd == '0) begin
          state_d = DONE;
          res_d   = '0;
          div0_d  = 1'b1;
        end else if (bcnt != BW'(WIDTH)) begin
          // dq shifts dividend bits out at the top and quotient bits in.
          bcnt_d = bcnt + BW'(1);
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            dq_d  = {dq[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = {rem[WIDTH-2:0], dq[WIDTH-1]};
            dq_d  = {dq[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = qneg ? -dq : dq;
          ovf_d = ovf | (!qneg && dq[WIDTH-1]);
          idx_d = idx_p1;
          if (!PREC && last_step) begin
            state_d = DONE;
            res_d   = acc_d;
          end else begin
            state_d = EVAL;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= COLLECT;
      cnt    <= '0;
      idx    <= '0;
      acc    <= '0;
      sum    <= '0;
      dq     <= '0;
      dd     <= '0;
      rem    <= '0;
      bcnt   <= '0;
      sgn    <= 1'b0;
      qneg   <= 1'b0;
      ovf    <= 1'b0;
      res_q  <= '0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      acc   <= acc_d;
      sum   <= sum_d;
      dq    <= dq_d;
      dd    <= dd_d;
      rem   <= rem_d;
      bcnt  <= bcnt_d;
      sgn   <= sgn_d;
      qneg  <= qneg_d;
      ovf   <= ovf_d;
      if (state != DONE && state_d == DONE) begin
        res_q  <= res_d;
        div0_q <= div0_d;
        ovf_q  <= ovf_d;
      end else if (state == DONE && out_ready) begin
        res_q  <= '0;
        div0_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
    end
  end

  // Token storage needs no reset: cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (in_valid && state == COLLECT) begin
      opnd[cnt] <= in_operand;
      ops[cnt]  <= in_op;
    end
  end

  assign in_ready   = (state == COLLECT);
  assign busy       = (state != COLLECT);
  assign out_valid  = (state == DONE);
  assign out_result = res_q;
  assign out_neg    = res_q[WIDTH-1];
  assign out_zero   = (res_q == '0);
  assign out_div0   = div0_q;
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_chain_alu.sv
// Self-checking bench for chain_alu (WIDTH=8, DEPTH=5): directed cases
// followed by random expressions, checked against an integer model.
module tb_chain_alu;
  localparam int W = 8;
  localparam int D = 5;

`ifdef CHAIN_ALU_PRECEDENCE_EN
  localparam bit PREC = 1'b1;
`else
  localparam bit PREC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_operand = '0;
  logic [1:0]   in_op = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_neg, out_zero, out_div0, out_ovf, busy;

  int passed = 0;
  int total  = 0;

  int         tv  [D];
  logic [1:0] top [D];

  chain_alu #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_operand(in_operand), .in_op(in_op), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_neg(out_neg), .out_zero(out_zero),
    .out_div0(out_div0), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int wrap(input int x);
    return (x <<< (32 - W)) >>> (32 - W);
  endfunction

  // Reference: evaluate the expression with plain integer arithmetic.
  function automatic void model(input int n, output int res, output bit ovf,
                                output bit dz, output int lat);
    int acc, sum, term, r, divs;
    bit sg;
    ovf = 0; dz = 0; divs = 0; res = 0;
    if (!PREC) begin
      acc = tv[0];
      for (int i = 0; i < n - 1; i++) begin
        case (top[i])
          2'd0: r = acc + tv[i+1];
          2'd1: r = acc - tv[i+1];
          2'd2: r = acc * tv[i+1];
          default: begin
            divs++;
            if (tv[i+1] == 0) begin dz = 1; break; end
            r = acc / tv[i+1];
          end
        endcase
        if (wrap(r) != r) ovf = 1;
        acc = wrap(r);
      end
      res = dz ? 0 : acc;
      lat = ((n > 1) ? n - 1 : 1) + divs * (W + 1);
    end else begin
      sum = 0; sg = 0; term = tv[0];
      for (int i = 0; i < n - 1; i++) begin
        if (top[i] == 2'd2 || top[i] == 2'd3) begin
          if (top[i] == 2'd2) r = term * tv[i+1];
          else begin
            divs++;
            if (tv[i+1] == 0) begin dz = 1; break; end
            r = term / tv[i+1];
          end
          if (wrap(r) != r) ovf = 1;
          term = wrap(r);
        end else begin
          r = sg ? sum - term : sum + term;
          if (wrap(r) != r) ovf = 1;
          sum = wrap(r);
          sg = top[i][0];
          term = tv[i+1];
        end
      end
      if (!dz) begin
        r = sg ? sum - term : sum + term;
        if (wrap(r) != r) ovf = 1;
        res = wrap(r);
      end
      lat = n + divs * (W + 1);
    end
  endfunction

  // Sends n tokens; returns #1 after the edge accepting the last one.
  task automatic send(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("in_ready_collect", {31'b0, in_ready}, 1);
      in_valid   = 1'b1;
      in_operand = W'(tv[i]);
      in_op      = top[i];
      in_last    = use_last && (i == n - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_expr(input int n, input bit use_last, input int hold);
    int er, elat, cyc;
    bit eovf, ediv0;
    model(n, er, eovf, ediv0, elat);
    send(n, use_last);
    chk("in_ready_drop", {31'b0, in_ready}, 0);
    chk("busy_eval", {31'b0, busy}, 1);
    cyc = 0;
    while (!out_valid && cyc < 80) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("out_valid", {31'b0, out_valid}, 1);
    if (!ediv0) chk("latency", cyc, elat);
    chk("result", $signed(out_result), er);
    chk("neg", {31'b0, out_neg}, (er < 0) ? 1 : 0);
    chk("zero", {31'b0, out_zero}, (er == 0) ? 1 : 0);
    chk("div0", {31'b0, out_div0}, {31'b0, ediv0});
    chk("ovf", {31'b0, out_ovf}, {31'b0, eovf});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_result", $signed(out_result), er);
      chk("hold_ovf", {31'b0, out_ovf}, {31'b0, eovf});
      chk("hold_in_ready", {31'b0, in_ready}, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_back", {31'b0, in_ready}, 1);
    chk("valid_cleared", {31'b0, out_valid}, 0);
    chk("div0_cleared", {31'b0, out_div0}, 0);
    chk("ovf_cleared", {31'b0, out_ovf}, 0);
    chk("neg_cleared", {31'b0, out_neg}, 0);
    chk("busy_cleared", {31'b0, busy}, 0);
  endtask

  initial begin
    int n;
    bit ul;
    // reset values
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_result", $signed(out_result), 0);
    chk("rst_neg", {31'b0, out_neg}, 0);
    chk("rst_zero", {31'b0, out_zero}, 1);
    chk("rst_div0", {31'b0, out_div0}, 0);
    chk("rst_ovf", {31'b0, out_ovf}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // (3,add) (-2,mul) (4,last)
    tv[0] = 3;  top[0] = 2'd0;
    tv[1] = -2; top[1] = 2'd2;
    tv[2] = 4;  top[2] = 2'd0;
    do_expr(3, 1, 0);
    // (-7,div) (2,last)
    tv[0] = -7; top[0] = 2'd3;
    tv[1] = 2;  top[1] = 2'd0;
    do_expr(2, 1, 0);
    // (7,div) (0,sub) (5,last)
    tv[0] = 7; top[0] = 2'd3;
    tv[1] = 0; top[1] = 2'd1;
    tv[2] = 5; top[2] = 2'd0;
    do_expr(3, 1, 0);
    // (100,add) (100,last)
    tv[0] = 100; top[0] = 2'd0;
    tv[1] = 100; top[1] = 2'd0;
    do_expr(2, 1, 0);
    // (-128,div) (-1,last)
    tv[0] = -128; top[0] = 2'd3;
    tv[1] = -1;   top[1] = 2'd0;
    do_expr(2, 1, 0);
    // single operand
    tv[0] = -9; top[0] = 2'd2;
    do_expr(1, 1, 0);
    // DEPTH tokens without in_last, consumer stalls 3 cycles
    tv[0] = 10; top[0] = 2'd1;
    tv[1] = 3;  top[1] = 2'd2;
    tv[2] = 2;  top[2] = 2'd0;
    tv[3] = 20; top[3] = 2'd3;
    tv[4] = 3;  top[4] = 2'd1;
    do_expr(5, 0, 3);

    // reset in the middle of a divide
    tv[0] = 100; top[0] = 2'd3;
    tv[1] = 3;   top[1] = 2'd0;
    send(2, 1);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tv[0] = 2; top[0] = 2'd0;
    tv[1] = 3; top[1] = 2'd0;
    do_expr(2, 1, 0);

    // random expressions
    for (int t = 0; t < 40; t++) begin
      n  = int'($urandom_range(1, D));
      ul = (n < D) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < D; i++) begin
        if ($urandom_range(0, 2) == 0) tv[i] = int'($urandom_range(0, 8)) - 4;
        else tv[i] = int'($urandom_range(0, 255)) - 128;
        top[i] = 2'($urandom_range(0, 3));
      end
      do_expr(n, ul, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
